scope_capture_ctrl: RTL and testbench

- Trigger/acquisition sequencer for the oscilloscope sample path, in the ad_clk domain next to the pulse/vpp/voltage measurement blocks.
- Decimates the AD stream and writes it circularly into the waveform RAM, keeping a pre-trigger history.
- Detects a trigger-level crossing, captures the post-trigger part, then holds the frame for the display reader until it is acknowledged.
- Supports stop, single, normal and auto (timeout-forced) run modes.

---
 rtl/scope_capture_ctrl_pkg.sv | 22 ++
 rtl/scope_trig_detect.sv | 40 ++++
 rtl/scope_capture_ctrl.sv | 122 ++++++++++++
 tb/tb_scope_capture_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/scope_capture_ctrl_pkg.sv
// Shared encodings for the scope trigger/acquisition sequencer.
package scope_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_HOLD
    } state_t;

    localparam logic [1:0] MODE_STOP   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_NORMAL = 2'd2;
    localparam logic [1:0] MODE_AUTO   = 2'd3;

    // Modes that re-arm by themselves after each frame.
    function automatic logic is_continuous(input logic [1:0] mode);
        return (mode == MODE_NORMAL) || (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Level-crossing detector: compares each strobed sample against the previous one.
module scope_trig_detect
    import scope_capture_ctrl_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] level,
    input  logic             edge_sel,
    output logic             hit
);

    logic [WIDTH-1:0] prev;
    logic             prev_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            if (ce) prev <= sample;
            // clr wins so the first sample after a restart has no predecessor
            if (clr)     prev_valid <= 1'b0;
            else if (ce) prev_valid <= 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        if (ce && prev_valid) begin
            if (edge_sel) hit = (prev > level) && (sample <= level);
            else          hit = (prev < level) && (sample >= level);
        end
    end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture sequencer: decimates the AD stream into a circular RAM,
// triggers on a level crossing and holds the frame until the display acks it.
module scope_capture_ctrl
    import scope_capture_ctrl_pkg::*;
#(
    parameter int          WIDTH    = 12,
    parameter int          AW       = 10,
    parameter int          PRE_TRIG = 256,
    parameter logic [19:0] AUTO_TO  = 20'd500_000
) (
    input  logic             ad_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ad_data,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_edge,
    input  logic [1:0]       run_mode,
    input  logic             arm,
    input  logic [15:0]      decim,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             frame_valid,
    output logic [AW-1:0]    frame_start,
    output logic             frame_forced,
    input  logic             frame_ack,
    output logic             busy,
    output state_t           fsm_state
);

    localparam logic [AW-1:0] PRE_LEN   = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'((1 << AW) - PRE_TRIG - 1);
    localparam bit            POST_ONE  = (PRE_TRIG == (1 << AW) - 1);

    state_t          state, state_next;
    logic [15:0]     dcnt;
    logic [AW-1:0]   waddr, pre_cnt, post_cnt;
    logic [19:0]     to_cnt;
    logic            ce, active, stop, write, hit, timeout, trig_take, entering_pre;
    logic            fv_q;

    assign ce           = (dcnt == decim);
    assign active       = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
    assign stop         = (run_mode == MODE_STOP);
    assign write        = ce && active && !stop;
    assign timeout      = ce && (run_mode == MODE_AUTO) && (to_cnt == AUTO_TO - 20'd1);
    assign trig_take    = (state == ST_ARMED) && !stop && (hit || timeout);
    assign entering_pre = (state_next == ST_PRE) && (state != ST_PRE);

    scope_trig_detect #(.WIDTH(WIDTH)) u_trig (
        .clk      (ad_clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .clr      (entering_pre),
        .sample   (ad_data),
        .level    (trig_level),
        .edge_sel (trig_edge),
        .hit      (hit)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (is_continuous(run_mode) || (run_mode == MODE_SINGLE && arm))
                          state_next = ST_PRE;
            ST_PRE:   if (stop) state_next = ST_IDLE;
                      else if (ce && pre_cnt == PRE_LAST) state_next = ST_ARMED;
            ST_ARMED: if (stop) state_next = ST_IDLE;
                      else if (trig_take) state_next = POST_ONE ? ST_HOLD : ST_POST;
            ST_POST:  if (stop) state_next = ST_IDLE;
                      else if (ce && post_cnt == POST_LAST) state_next = ST_HOLD;
            ST_HOLD:  if (frame_ack)
                          state_next = is_continuous(run_mode) ? ST_PRE : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ad_clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dcnt         <= '0;
            waddr        <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            to_cnt       <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_start  <= '0;
            frame_forced <= 1'b0;
            fv_q         <= 1'b0;
        end else begin
            state <= state_next;
            dcnt  <= ce ? 16'd0 : dcnt + 16'd1;
            wr_en <= write;
            if (write) begin
                wr_addr <= waddr;
                wr_data <= ad_data;
                waddr   <= waddr + 1'b1;
            end
            if (state != ST_PRE) pre_cnt <= '0;
            else if (ce)         pre_cnt <= pre_cnt + 1'b1;
            // The trigger sample itself is post-sample #1, so POST starts at 1.
            if (state != ST_POST) post_cnt <= {{(AW-1){1'b0}}, 1'b1};
            else if (ce)          post_cnt <= post_cnt + 1'b1;
            if (state != ST_ARMED || run_mode != MODE_AUTO) to_cnt <= '0;
            else if (ce)                                    to_cnt <= to_cnt + 20'd1;
            if (trig_take) begin
                frame_start  <= waddr - PRE_LEN;
                frame_forced <= !hit;
            end
            // frame_valid/frame_ack: valid rises the cycle after the last write
            // lands and stays high until the cycle after a one-cycle ack.
            fv_q <= (state == ST_HOLD) && !frame_ack;
        end
    end

    assign frame_valid = fv_q;
    assign busy        = active;
    assign fsm_state   = state;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl with AW=4, PRE_TRIG=4, AUTO_TO=20.
module tb_scope_capture_ctrl;
    import scope_capture_ctrl_pkg::*;

    logic        ad_clk = 1'b0;
    logic        rst_n;
    logic [11:0] ad_data, trig_level;
    logic        trig_edge, arm, frame_ack;
    logic [1:0]  run_mode;
    logic [15:0] decim;
    logic        wr_en, frame_valid, frame_forced, busy;
    logic [3:0]  wr_addr, frame_start;
    logic [11:0] wr_data;
    state_t      fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    scope_capture_ctrl #(.WIDTH(12), .AW(4), .PRE_TRIG(4), .AUTO_TO(20'd20)) dut (
        .ad_clk       (ad_clk),
        .rst_n        (rst_n),
        .ad_data      (ad_data),
        .trig_level   (trig_level),
        .trig_edge    (trig_edge),
        .run_mode     (run_mode),
        .arm          (arm),
        .decim        (decim),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_valid  (frame_valid),
        .frame_start  (frame_start),
        .frame_forced (frame_forced),
        .frame_ack    (frame_ack),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    always #5 ad_clk = ~ad_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        arm       = 1'b0;
        frame_ack = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    // Sample value presented before edge e (edge 1 is the first after reset/arm).
    function automatic logic [11:0] pat_val(input int pat, input int e);
        case (pat)
            0:       return 12'(100 * (e - 1));
            1:       return 12'd500;
            2:       return (e < 8) ? 12'd2000 : (e == 8) ? 12'd1500 : 12'd900;
            3:       return (e < 8) ? 12'd2000 : (e == 8) ? 12'd1500 : 12'd1000;
            default: return (e >= 8) ? 12'd2000 : 12'd0;
        endcase
    endfunction

    task automatic run_until_valid(input int pat, input int budget,
                                   output int nv, output int nw, output int ta);
        nv = -1;
        nw = 0;
        ta = -1;
        ad_data = pat_val(pat, 1);
        for (int e = 1; e <= budget; e++) begin
            step();
            arm = 1'b0;
            if (wr_en) begin
                nw++;
                if (wr_data == 12'd1000) ta = int'(wr_addr);
            end
            if (frame_valid) begin
                nv = e;
                break;
            end
            ad_data = pat_val(pat, e + 1);
        end
    endtask

    initial begin
        int nv, nw, ta, cnt, first_e, last_e, bad_gap, bad_addr, wraps;
        logic [3:0] last_a;

        ad_data = '0; trig_level = 12'd1000; trig_edge = 1'b0;
        run_mode = MODE_STOP; decim = 16'd0;
        do_reset();
        check("reset_outputs", {wr_en, wr_addr, wr_data, frame_valid, frame_start, frame_forced, busy}, 0);
        check("reset_state", fsm_state, ST_IDLE);

        // 1: normal mode, rising ramp, trigger on the 1000 sample
        run_mode = MODE_NORMAL;
        do_reset();
        run_until_valid(0, 100, nv, nw, ta);
        check("t1_valid_cycle", nv, 23);
        check("t1_writes", nw, 21);
        check("t1_trig_addr", ta, 9);
        check("t1_frame_start", frame_start, 5);
        check("t1_forced", frame_forced, 0);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("t1_valid_after_ack", frame_valid, 0);
        check("t1_rearm_busy", busy, 1);

        // 2: auto mode, no crossing, forced after 20 armed strobes
        run_mode = MODE_AUTO;
        do_reset();
        run_until_valid(1, 100, nv, nw, ta);
        check("t2_valid_cycle", nv, 37);
        check("t2_writes", nw, 35);
        check("t2_frame_start", frame_start, 3);
        check("t2_forced", frame_forced, 1);

        // 3: decim = 3, write spacing and address wrap
        run_mode = MODE_NORMAL; decim = 16'd3; ad_data = 12'd100;
        do_reset();
        cnt = 0; first_e = 0; last_e = 0; bad_gap = 0; bad_addr = 0; wraps = 0; last_a = '0;
        for (int e = 1; e <= 120; e++) begin
            step();
            if (wr_en) begin
                if (cnt == 0) first_e = e;
                else begin
                    if (e - last_e != 4) bad_gap++;
                    if (wr_addr != 4'(last_a + 1)) bad_addr++;
                    if (wr_addr == 4'd0) wraps++;
                end
                last_e = e;
                last_a = wr_addr;
                cnt++;
                if (cnt == 20) break;
            end
        end
        check("t3_write_count", cnt, 20);
        check("t3_first_write", first_e, 4);
        check("t3_gap", bad_gap, 0);
        check("t3_addr_seq", bad_addr, 0);
        check("t3_wraps", wraps, 1);
        check("t3_last_addr", last_a, 3);
        decim = 16'd0;

        // 4: single mode
        run_mode = MODE_SINGLE; ad_data = '0;
        do_reset();
        cnt = 0;
        repeat (5) begin
            step();
            if (wr_en) cnt++;
        end
        check("t4_idle_busy", busy, 0);
        check("t4_idle_writes", cnt, 0);
        arm = 1'b1;
        run_until_valid(4, 100, nv, nw, ta);
        check("t4_valid_cycle", nv, 20);
        check("t4_frame_start", frame_start, 2);
        check("t4_forced", frame_forced, 0);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("t4_busy_after_ack", busy, 0);
        check("t4_valid_after_ack", frame_valid, 0);
        cnt = 0;
        repeat (10) begin
            step();
            if (wr_en) cnt++;
        end
        check("t4_no_writes", cnt, 0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("t4_rearm_busy", busy, 1);

        // 5: falling edge, 900 then the equal-to-level case
        run_mode = MODE_NORMAL; trig_edge = 1'b1;
        do_reset();
        run_until_valid(2, 100, nv, nw, ta);
        check("t5a_valid_cycle", nv, 21);
        check("t5a_frame_start", frame_start, 3);
        check("t5a_forced", frame_forced, 0);
        do_reset();
        run_until_valid(3, 100, nv, nw, ta);
        check("t5b_valid_cycle", nv, 21);
        check("t5b_frame_start", frame_start, 3);
        check("t5b_forced", frame_forced, 0);
        trig_edge = 1'b0;

        // 6a: stray ack in ARMED is ignored, then stop aborts
        ad_data = 12'd100;
        do_reset();
        repeat (8) step();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("t6a_ack_ignored", busy, 1);
        run_mode = MODE_STOP;
        step();
        check("t6a_busy", busy, 0);
        check("t6a_valid", frame_valid, 0);
        check("t6a_wr_en", wr_en, 0);
        check("t6a_state", fsm_state, ST_IDLE);

        // 6b: reset during POST
        run_mode = MODE_NORMAL;
        do_reset();
        ad_data = pat_val(0, 1);
        for (int e = 1; e <= 15; e++) begin
            step();
            ad_data = pat_val(0, e + 1);
        end
        check("t6b_in_post", fsm_state, ST_POST);
        rst_n = 1'b0;
        step();
        check("t6b_reset_outputs", {wr_en, wr_addr, wr_data, frame_valid, frame_start, frame_forced, busy}, 0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
